// File: rtl/hazard_pkg.sv
// ----------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the pipeline stall/flush scheduler.
//   REG_IDX_W  : width of a register-file index
//   HazState_t : scheduler state (RUN, MDU_WAIT, DC_WAIT)
//   PipeCtrl_t : PC write enable plus per-stage stall/flush bundle
// ----------------------------------------------------------------------------
package hazard_pkg;

   localparam int unsigned REG_IDX_W = 5;

   typedef enum logic [1:0] {
      RUN,
      MDU_WAIT,
      DC_WAIT
   } HazState_t;

   typedef struct packed {
      logic pc_wr;
      logic if_id_stall;
      logic id_exe_stall;
      logic exe_mem_stall;
      logic mem_wb_stall;
      logic if_id_flush;
      logic id_exe_flush;
      logic exe_mem_flush;
   } PipeCtrl_t;

endpackage

// File: rtl/load_use_detect.sv
// ----------------------------------------------------------------------------
// load_use_detect
// Flags an ID-stage source operand that depends on a load the forwarding path
// cannot serve: a load in EXE (data not yet read) or a load in MEM (data only
// valid in WB). Register 0 never creates a dependency.
//   rs, rt, read_rs, read_rt        : ID operand indices and read enables
//   exe_dst, exe_rf_wr, exe_mem_read: EXE destination / write / load flags
//   mem_dst, mem_mem_read           : MEM destination / load flag
//   hazard                          : ID must wait one cycle
// ----------------------------------------------------------------------------
module load_use_detect
   import hazard_pkg::*;
(
   input  logic [REG_IDX_W-1:0] rs,
   input  logic [REG_IDX_W-1:0] rt,
   input  logic                 read_rs,
   input  logic                 read_rt,
   input  logic [REG_IDX_W-1:0] exe_dst,
   input  logic                 exe_rf_wr,
   input  logic                 exe_mem_read,
   input  logic [REG_IDX_W-1:0] mem_dst,
   input  logic                 mem_mem_read,
   output logic                 hazard
);

   logic exe_match;
   logic mem_match;
   logic exe_hit;
   logic mem_hit;

   assign exe_match = (read_rs && (rs == exe_dst)) || (read_rt && (rt == exe_dst));
   assign mem_match = (read_rs && (rs == mem_dst)) || (read_rt && (rt == mem_dst));

   assign exe_hit = exe_mem_read && exe_rf_wr && (exe_dst != '0) && exe_match;
   assign mem_hit = mem_mem_read && (mem_dst != '0) && mem_match;

   assign hazard = exe_hit || mem_hit;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_stall_ctrl
// Central stall/flush scheduler for the 5-stage pipeline. Priority each cycle:
// MEM exception > D-cache wait > MDU wait > load-use.
//   clk, resetn           : clock, asynchronous active-low reset
//   ID_*/EXE_*/MEM_*      : operand/destination info for hazard detection
//   EXE_MduStart, MDU_Done: multi-cycle mult/div handshake
//   DCache_Busy           : D-cache miss pending for the MEM instruction
//   MEM_Exception         : exception/eret committed in MEM
//   PC_Wr, *_Stall, *_Flush: pipeline register controls (0 during reset)
//   MDU_Cancel            : abort the in-flight MDU op
//   err_mdu_timeout       : registered one-cycle pulse after an MDU timeout
// Optional (macro HAZARD_PERF_CNT_EN): perf_clr input and saturating
// stall_cycles output counting cycles with PC_Wr low.
// ----------------------------------------------------------------------------
module hazard_stall_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned MDU_TIMEOUT = 64
`ifdef HAZARD_PERF_CNT_EN
   ,
   parameter int unsigned STALL_CNT_W = 32
`endif
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [REG_IDX_W-1:0] ID_rs,
   input  logic [REG_IDX_W-1:0] ID_rt,
   input  logic                 ID_ReadRs,
   input  logic                 ID_ReadRt,
   input  logic [REG_IDX_W-1:0] EXE_Dst,
   input  logic                 EXE_RFWr,
   input  logic                 EXE_MemRead,
   input  logic [REG_IDX_W-1:0] MEM_Dst,
   input  logic                 MEM_MemRead,
   input  logic                 EXE_MduStart,
   input  logic                 MDU_Done,
   input  logic                 DCache_Busy,
   input  logic                 MEM_Exception,
   output logic                 PC_Wr,
   output logic                 IF_ID_Stall,
   output logic                 ID_EXE_Stall,
   output logic                 EXE_MEM_Stall,
   output logic                 MEM_WB_Stall,
   output logic                 IF_ID_Flush,
   output logic                 ID_EXE_Flush,
   output logic                 EXE_MEM_Flush,
   output logic                 MDU_Cancel,
   output logic                 err_mdu_timeout
`ifdef HAZARD_PERF_CNT_EN
   ,
   input  logic                   perf_clr,
   output logic [STALL_CNT_W-1:0] stall_cycles
`endif
);

   localparam int unsigned CntW = $clog2(MDU_TIMEOUT + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(MDU_TIMEOUT - 1);

   HazState_t       state_q, state_d;
   HazState_t       eff_state;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            ret_q, ret_d;     // miss interrupted an outstanding MDU op
   logic            err_q;
   logic            timeout_c;
   logic            cancel_c;
   logic            load_use;
   PipeCtrl_t       ctrl;

   load_use_detect u_load_use_detect (
      .rs           (ID_rs),
      .rt           (ID_rt),
      .read_rs      (ID_ReadRs),
      .read_rt      (ID_ReadRt),
      .exe_dst      (EXE_Dst),
      .exe_rf_wr    (EXE_RFWr),
      .exe_mem_read (EXE_MemRead),
      .mem_dst      (MEM_Dst),
      .mem_mem_read (MEM_MemRead),
      .hazard       (load_use)
   );

   always_comb begin
      // Once the miss clears, DC_WAIT already behaves as the state it returns
      // to, so the release cycle is not wasted.
      eff_state = state_q;
      if (state_q == DC_WAIT && !DCache_Busy) begin
         eff_state = ret_q ? MDU_WAIT : RUN;
      end

      ctrl      = '0;
      cancel_c  = 1'b0;
      timeout_c = 1'b0;
      state_d   = eff_state;
      cnt_d     = cnt_q;
      ret_d     = ret_q;

      if (MEM_Exception) begin
         ctrl.pc_wr         = 1'b1;
         ctrl.if_id_flush   = 1'b1;
         ctrl.id_exe_flush  = 1'b1;
         ctrl.exe_mem_flush = 1'b1;
         // An MDU op parked behind a miss is still in flight and must die too.
         cancel_c = (eff_state == MDU_WAIT) || (eff_state == DC_WAIT && ret_q) ||
                    EXE_MduStart;
         state_d  = RUN;
         cnt_d    = '0;
         ret_d    = 1'b0;
      end else if (DCache_Busy) begin
         ctrl.if_id_stall   = 1'b1;
         ctrl.id_exe_stall  = 1'b1;
         ctrl.exe_mem_stall = 1'b1;
         ctrl.mem_wb_stall  = 1'b1;
         state_d = DC_WAIT;
         if (eff_state == DC_WAIT) begin
            ret_d = ret_q && !MDU_Done;
         end else begin
            ret_d = (eff_state == MDU_WAIT) && !MDU_Done;
         end
      end else if (eff_state == MDU_WAIT) begin
         // MEM_WB keeps moving so the instruction ahead of the MDU op retires.
         ctrl.if_id_stall   = 1'b1;
         ctrl.id_exe_stall  = 1'b1;
         ctrl.exe_mem_stall = 1'b1;
         ret_d = 1'b0;
         if (MDU_Done) begin
            state_d = RUN;
            cnt_d   = '0;
         end else if (cnt_q == CntLast) begin
            timeout_c = 1'b1;
            cancel_c  = 1'b1;
            state_d   = RUN;
            cnt_d     = '0;
         end else begin
            state_d = MDU_WAIT;
            cnt_d   = cnt_q + CntW'(1);
         end
      end else begin
         ret_d = 1'b0;
         cnt_d = '0;
         if (load_use) begin
            ctrl.if_id_stall  = 1'b1;
            ctrl.id_exe_flush = 1'b1;
         end else begin
            ctrl.pc_wr = 1'b1;
         end
         state_d = EXE_MduStart ? MDU_WAIT : RUN;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= RUN;
         cnt_q   <= '0;
         ret_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ret_q   <= ret_d;
         err_q   <= timeout_c;
      end
   end

   // Reset forces every control low immediately, independent of the clock.
   assign PC_Wr           = resetn & ctrl.pc_wr;
   assign IF_ID_Stall     = resetn & ctrl.if_id_stall;
   assign ID_EXE_Stall    = resetn & ctrl.id_exe_stall;
   assign EXE_MEM_Stall   = resetn & ctrl.exe_mem_stall;
   assign MEM_WB_Stall    = resetn & ctrl.mem_wb_stall;
   assign IF_ID_Flush     = resetn & ctrl.if_id_flush;
   assign ID_EXE_Flush    = resetn & ctrl.id_exe_flush;
   assign EXE_MEM_Flush   = resetn & ctrl.exe_mem_flush;
   assign MDU_Cancel      = resetn & cancel_c;
   assign err_mdu_timeout = err_q;

`ifdef HAZARD_PERF_CNT_EN
   logic [STALL_CNT_W-1:0] stall_cnt_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stall_cnt_q <= '0;
      end else if (perf_clr) begin
         stall_cnt_q <= '0;
      end else if (!PC_Wr && (stall_cnt_q != '1)) begin
         stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
      end
   end

   assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Central stall/flush scheduler for the 5-stage integer pipeline. Combines load-use hazards (cases the EXE-stage forwarding path cannot cover), multi-cycle MDU (mult/div) occupancy, D-cache miss waits and MEM-stage exceptions. Produces per-stage stall/flush controls, PC write-enable and MDU cancel. Sits beside the ID/EXE forwarding logic and drives every pipeline register.

Parameters:
MDU_TIMEOUT, 64, max cycles in MDU_WAIT before forced exit with err_mdu_timeout pulse
STALL_CNT_W, 32, width of performance stall counter (used only with feature enabled)

Ports:
clk  in  1  pipeline clock
resetn  in  1  asynchronous active-low reset
ID_rs  in  5  rs index of instruction in ID
ID_rt  in  5  rt index of instruction in ID
ID_ReadRs  in  1  ID instruction reads rs
ID_ReadRt  in  1  ID instruction reads rt
EXE_Dst  in  5  destination of instruction in EXE
EXE_RFWr  in  1  EXE instruction writes register file
EXE_MemRead  in  1  EXE instruction is a load
MEM_Dst  in  5  destination of instruction in MEM
MEM_MemRead  in  1  MEM instruction is a load (data valid only in WB)
EXE_MduStart  in  1  EXE instruction starts multi-cycle MDU op (1-cycle pulse per op)
MDU_Done  in  1  MDU result valid
DCache_Busy  in  1  D-cache miss/uncached access pending for MEM instruction
MEM_Exception  in  1  exception/eret committed in MEM
PC_Wr  out  1  PC register write enable
IF_ID_Stall, ID_EXE_Stall, EXE_MEM_Stall, MEM_WB_Stall  out  1 each  hold register
IF_ID_Flush, ID_EXE_Flush, EXE_MEM_Flush  out  1 each  insert bubble
MDU_Cancel  out  1  abort in-flight MDU op
err_mdu_timeout  out  1  one-cycle pulse on timeout

Behaviour:
- Asynchronous reset: state=RUN, timeout counter=0, err_mdu_timeout=0. While resetn low all stall/flush/MDU_Cancel outputs 0, PC_Wr=0.
- Outputs combinational from state and inputs; state/counter registered on clk rising edge.
- States: RUN, MDU_WAIT, DC_WAIT.
- Priority every cycle (highest first): MEM_Exception > DCache_Busy > MDU wait > load-use.
- MEM_Exception=1 (any state): IF_ID_Flush, ID_EXE_Flush, EXE_MEM_Flush=1; stalls all 0; PC_Wr=1 (redirect); MDU_Cancel=1 if state==MDU_WAIT or EXE_MduStart; next state RUN, counter cleared. Exception outranks DCache_Busy (MEM owns the miss; cache drops it).
- DCache_Busy=1 (no exception): all four stalls=1, PC_Wr=0, no flush; next state DC_WAIT. DC_WAIT remains while DCache_Busy; on deassert returns to MDU_WAIT if entered from MDU_WAIT with MDU_Done not yet seen (sticky return flag), else RUN.
- EXE_MduStart in RUN: next state MDU_WAIT. In MDU_WAIT: PC_Wr=0, IF_ID/ID_EXE/EXE_MEM_Stall=1, MEM_WB_Stall=0, EXE_MEM_Flush=0 (EXE held, MEM drains via stall-free WB). Exit to RUN the cycle after MDU_Done=1; that cycle releases stalls. MDU_Done arriving during DC_WAIT clears the return flag.
- Counter increments each MDU_WAIT cycle; reaching MDU_TIMEOUT-1 without MDU_Done: err_mdu_timeout=1 for one cycle, MDU_Cancel=1, next state RUN.
- Load-use (RUN only, no higher event): hazard if (EXE_MemRead && EXE_RFWr && EXE_Dst!=0 && matches ID rs/rt read) or (MEM_MemRead && MEM_Dst!=0 && matches). Response: PC_Wr=0, IF_ID_Stall=1, ID_EXE_Flush=1, others 0. Zero-register match never stalls.
- Otherwise RUN: PC_Wr=1, all stall/flush 0.

Optional Feature:
HAZARD_PERF_CNT_EN: adds output stall_cycles[STALL_CNT_W-1:0] plus input perf_clr; counts cycles with PC_Wr=0 while resetn high; saturates at all-ones; perf_clr synchronous clear with priority over increment. Without macro: no port, no counter.

Decomposition:
- Package hazard_pkg: state enum HazState_t {RUN, MDU_WAIT, DC_WAIT}, PipeCtrl_t struct (stall/flush bundle, PC_Wr), reg-index width constant.
- One sub-module: load_use_detect (combinational rs/rt match against EXE/MEM loads).

Test Plan:
- EXE load to $5, ID reads rs=$5 -> 1 cycle PC_Wr=0, IF_ID_Stall=1, ID_EXE_Flush=1; next cycle (load in MEM) again bubble; then RUN.
- Load to $0 with ID rs=$0 -> no stall, PC_Wr=1.
- EXE_MduStart, MDU_Done after 10 cycles -> 10 cycles MDU_WAIT stalls; release on the 11th; state RUN.
- MDU_WAIT, DCache_Busy 3 cycles, MDU_Done during DC_WAIT -> all stalls 3 cycles, then RUN (not MDU_WAIT).
- MEM_Exception during MDU_WAIT with DCache_Busy=1 -> three flushes, PC_Wr=1, MDU_Cancel=1, next RUN.
- MDU_Done never asserted, MDU_TIMEOUT=64 -> err_mdu_timeout pulses after 64th cycle, MDU_Cancel=1; resetn dropped mid-MDU_WAIT -> outputs immediately 0, state RUN.
